multi_cycle_ctrl: RTL

//   Multi-cycle sequencer for the MIPS datapath. Steps each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/mips_pkg.sv | 45 ++++
 rtl/mem_wait_timer.sv | 53 +++++
 rtl/multi_cycle_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
//============================================================================
// Module   : mips_pkg
// Purpose  : Shared opcode/funct constants, sequencer state encoding and
//            instruction-class helpers for the multi-cycle MIPS controller.
// Ports    : none (package)
// Revision : 1.0 - initial release
//============================================================================
package mips_pkg;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes, instr[5:0]
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Sequencer state encoding (visible on the state output)
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

    // Control-transfer instructions retire straight out of EXEC.
    function automatic logic is_jump(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_J)   || (op == OP_JAL) ||
               (op == OP_BEQ) || (op == OP_BNE) ||
               ((op == OP_RTYPE) && (funct == FN_JR));
    endfunction

    // Loads and stores need the shared memory port a second time.
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
//============================================================================
// Module   : mem_wait_timer
// Purpose  : Counts cycles spent waiting for a memory acknowledge and flags
//            when the configured limit has been reached.
// Ports    : clk     in  system clock
//            rst     in  asynchronous active-high reset
//            clear   in  reset the count to zero (wins over count)
//            count   in  advance the count by one
//            expired out count equals MEM_TIMEOUT (never set when
//                        MEM_TIMEOUT is 0)
// Revision : 1.0 - initial release
//============================================================================
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);

    generate
        if (MEM_TIMEOUT > 0) begin : g_timer
            localparam int                 c_CNT_W = $clog2(MEM_TIMEOUT + 1);
            localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(MEM_TIMEOUT);

            logic [c_CNT_W-1:0] r_wait_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_wait_cnt <= '0;
                end else if (clear) begin
                    r_wait_cnt <= '0;
                end else if (count && (r_wait_cnt != c_LIMIT)) begin
                    // Saturate at the limit so the counter cannot wrap back
                    // below it if the owner keeps counting.
                    r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
                end
            end

            assign expired = (r_wait_cnt == c_LIMIT);
        end else begin : g_no_timer
            // Timeout disabled: the inputs are intentionally left unused.
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, clear, count};
            assign expired  = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
//============================================================================
// Module   : multi_cycle_ctrl
// Purpose  : Multi-cycle sequencer for the MIPS datapath. Steps each
//            instruction through FETCH/DECODE/EXEC/MEM/WB, gates the decode
//            write strobes to the right cycle, drives PC/IR write enables and
//            handshakes with a single shared instruction/data memory port.
// Ports    : clk          in  system clock, rising edge
//            rst          in  asynchronous active-high reset
//            op           in  instr[31:26]
//            funct        in  instr[5:0]
//            regWr_dec    in  RegFile write strobe from decode
//            memWr_dec    in  Mem write strobe from decode
//            mem_ack      in  memory finished the current access
//            mem_req      out memory access request
//            mem_sel      out 0 = instruction fetch, 1 = data access
//            ir_we        out latch fetched instruction
//            pc_we        out PC update, one pulse per retired instruction
//            regWr        out gated RegFile write enable
//            memWr        out gated Mem write enable
//            state        out current sequencer state
//            timeout_err  out memory timeout, held until reset
//            instr_cnt    out retired-instruction count (wraps)
// Revision : 1.0 - initial release
//============================================================================
module multi_cycle_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             regWr_dec,
    input  logic             memWr_dec,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             regWr,
    output logic             memWr,
    output logic [2:0]       state,
    output logic             timeout_err,
    output logic [CNT_W-1:0] instr_cnt
);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_instr_cnt;

    logic w_in_access;
    logic w_wait_clear;
    logic w_wait_count;
    logic w_wait_expired;

    // The wait counter only runs while the memory port is owned. Clearing it
    // whenever we are outside FETCH/MEM, or on the ack that ends an access,
    // guarantees it starts from zero on every entry to FETCH or MEM.
    assign w_in_access  = (r_state == ST_FETCH) || (r_state == ST_MEM);
    assign w_wait_clear = !w_in_access || mem_ack;
    assign w_wait_count = w_in_access && !mem_ack;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_wait_clear),
        .count   (w_wait_count),
        .expired (w_wait_expired)
    );

    // Next-state and output decode. Outputs depend on mem_ack in FETCH/MEM so
    // the IR latch and store retirement happen in the ack cycle itself.
    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        mem_sel     = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        regWr       = 1'b0;
        memWr       = 1'b0;
        timeout_err = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end

            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we       = 1'b1;
                    w_state_nxt = ST_DECODE;
                end else if (w_wait_expired) begin
                    // An ack arriving on the limit cycle takes the branch above.
                    w_state_nxt = ST_ERR;
                end
            end

            ST_DECODE: begin
                w_state_nxt = ST_EXEC;
            end

            ST_EXEC: begin
                if (is_jump(op, funct)) begin
                    // jal needs its link write here; other jumps have
                    // regWr_dec low.
                    pc_we       = 1'b1;
                    regWr       = regWr_dec;
                    w_state_nxt = ST_FETCH;
                end else if (is_mem_op(op)) begin
                    w_state_nxt = ST_MEM;
                end else begin
                    w_state_nxt = ST_WB;
                end
            end

            ST_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                memWr   = memWr_dec;
                if (mem_ack) begin
                    if (op == OP_SW) begin
                        pc_we       = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_state_nxt = ST_WB;
                    end
                end else if (w_wait_expired) begin
                    w_state_nxt = ST_ERR;
                end
            end

            ST_WB: begin
                regWr       = regWr_dec;
                pc_we       = 1'b1;
                w_state_nxt = ST_FETCH;
            end

            ST_ERR: begin
                timeout_err = 1'b1;
            end

            default: begin
                // Unused encoding: restart the sequence cleanly.
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_instr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            // pc_we marks retirement, so it doubles as the count strobe.
            if (pc_we) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
        end
    end

    assign state     = r_state;
    assign instr_cnt = r_instr_cnt;

endmodule
`default_nettype wire
